nxn_board_game: RTL

- Parametrised successor to the fixed 3x3 two-player board controller. Supports an N x N board, one move per player strobe, and a win condition of a full row, column or diagonal.
- Adds features the 3x3 controller lacks: strict turn enforcement, configurable first player, draw detection, move counter, game_over flag and a synchronous new_game restart.
- Sits between the player input debouncers and the board display/LED driver.

---
 rtl/nxn_board_game.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/nxn_board_game.sv
// nxn_board_game: two-player N x N board controller with strict turns,
// win/draw detection, a move counter and a synchronous new-game restart.
module nxn_board_game #(
    parameter  int N            = 3,
    parameter  int FIRST_PLAYER = 0,
    localparam int POS_W        = $clog2(N*N),
    localparam int CNT_W        = $clog2(N*N+1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 new_game,
    input  logic                 p1,
    input  logic                 p2,
    input  logic [POS_W-1:0]     p1_pos,
    input  logic [POS_W-1:0]     p2_pos,
    output logic [2*N*N-1:0]     board,
    output logic [1:0]           winner,
    output logic                 game_over,
    output logic                 turn,
    output logic [CNT_W-1:0]     move_count,
    output logic                 illegal_move
);

    typedef enum logic [1:0] {PLAY, CHECK, DONE} state_t;

    localparam logic [POS_W:0]   CELLS_POS  = (POS_W+1)'(N*N);
    localparam logic [CNT_W-1:0] CELLS_CNT  = CNT_W'(N*N);
    localparam logic             TURN_START = (FIRST_PLAYER != 0);

    state_t               state, state_next;
    logic                 p1_q, p2_q;
    logic                 rise1, rise2;
    logic [2*N*N-1:0]     board_next;
    logic [1:0]           winner_next;
    logic                 turn_next;
    logic [CNT_W-1:0]     move_count_next;
    logic                 illegal_next;
    logic [1:0]           mover_code;
    logic [POS_W-1:0]     move_pos;
    logic                 pos_ok;
    logic                 cell_free;
    logic                 right_player;

    // True when every cell of some row, column or diagonal holds the given code.
    function automatic logic line_full(input logic [2*N*N-1:0] b, input logic [1:0] code);
        logic any_line, row_ok, col_ok, diag_ok, anti_ok;
        any_line = 1'b0;
        diag_ok  = 1'b1;
        anti_ok  = 1'b1;
        for (int r = 0; r < N; r++) begin
            row_ok = 1'b1;
            col_ok = 1'b1;
            for (int c = 0; c < N; c++) begin
                row_ok = row_ok & (b[2*(r*N+c) +: 2] == code);
                col_ok = col_ok & (b[2*(c*N+r) +: 2] == code);
            end
            any_line = any_line | row_ok | col_ok;
            diag_ok  = diag_ok & (b[2*(r*N+r) +: 2] == code);
            anti_ok  = anti_ok & (b[2*(r*N+N-1-r) +: 2] == code);
        end
        return any_line | diag_ok | anti_ok;
    endfunction

    assign rise1        = p1 & ~p1_q;
    assign rise2        = p2 & ~p2_q;
    assign mover_code   = turn ? 2'b10 : 2'b01;
    assign move_pos     = rise1 ? p1_pos : p2_pos;
    assign pos_ok       = ({1'b0, move_pos} < CELLS_POS);
    assign cell_free    = pos_ok && (board[2*move_pos +: 2] == 2'b00);
    assign right_player = (rise1 && !turn) || (rise2 && turn);
    assign game_over    = (state == DONE);

    // Register the strobes so only their rising edges count as moves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1_q <= 1'b0;
            p2_q <= 1'b0;
        end else begin
            p1_q <= p1;
            p2_q <= p2;
        end
    end

    // State register together with the board, score and turn bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= PLAY;
            board        <= '0;
            winner       <= 2'b00;
            turn         <= TURN_START;
            move_count   <= '0;
            illegal_move <= 1'b0;
        end else begin
            state        <= state_next;
            board        <= board_next;
            winner       <= winner_next;
            turn         <= turn_next;
            move_count   <= move_count_next;
            illegal_move <= illegal_next;
        end
    end

    // Next-state logic: accept or reject moves in PLAY, judge the last move in CHECK.
    always_comb begin
        state_next      = state;
        board_next      = board;
        winner_next     = winner;
        turn_next       = turn;
        move_count_next = move_count;
        illegal_next    = 1'b0;

        if (new_game) begin
            state_next      = PLAY;
            board_next      = '0;
            winner_next     = 2'b00;
            turn_next       = TURN_START;
            move_count_next = '0;
        end else begin
            case (state)
                PLAY: begin
                    if (rise1 && rise2) begin
                        illegal_next = 1'b1;
                    end else if (rise1 || rise2) begin
                        if (right_player && cell_free) begin
                            board_next[2*move_pos +: 2] = mover_code;
                            move_count_next             = move_count + CNT_W'(1);
                            state_next                  = CHECK;
                        end else begin
                            illegal_next = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    illegal_next = rise1 | rise2;
                    if (line_full(board, mover_code)) begin
                        winner_next = mover_code;
                        state_next  = DONE;
                    end else if (move_count == CELLS_CNT) begin
                        winner_next = 2'b11;
                        state_next  = DONE;
                    end else begin
                        turn_next  = ~turn;
                        state_next = PLAY;
                    end
                end
                DONE: begin
                    illegal_next = rise1 | rise2;
                end
                default: begin
                    state_next = PLAY;
                end
            endcase
        end
    end

endmodule
